// File: rtl/pueo_pattern_gen.sv
// Channel-data stimulus generator for the aclk domain: zero / ramp / constant / periodic
// impulse patterns plus manual and automatic trigger-time strobes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | outputs zero, config tracks inputs, counters at their seeds
// RUN   | one beat per edge from latched config; counters advance
module pueo_pattern_gen #(
   parameter int NCHAN     = 8,
   parameter int NSAMP     = 8,
   parameter int NBITS     = 12,
   parameter int RAMP_BITS = 8,
   parameter int TAG_MOD   = 4,
   parameter int TBITS     = 16
) (
   input  logic                         aclk_i,
   input  logic                         aclk_rst_i,
   input  logic                         run_i,
   input  logic [1:0]                   mode_i,
   input  logic [NBITS-1:0]             const_i,
   input  logic [15:0]                  pulse_period_i,
   input  logic [$clog2(NSAMP)-1:0]     pulse_pos_i,
   input  logic [NBITS-1:0]             pulse_amp_i,
   input  logic                         trig_req_i,
   input  logic [TBITS-1:0]             trig_time_req_i,
   output logic [NCHAN*NSAMP*NBITS-1:0] ch_dat_o,
   output logic                         ch_valid_o,
   output logic [TBITS-1:0]             trig_time_o,
   output logic                         trig_time_valid_o,
   output logic                         trig_err_o
);

   localparam int POSW = $clog2(NSAMP);
   localparam logic [1:0] M_ZERO  = 2'd0;
   localparam logic [1:0] M_RAMP  = 2'd1;
   localparam logic [1:0] M_CONST = 2'd2;
   localparam logic [1:0] M_PULSE = 2'd3;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t               state;
   logic [1:0]           mode_q;
   logic [NBITS-1:0]     const_q;
   logic [15:0]          per_q;
   logic [POSW-1:0]      pos_q;
   logic [NBITS-1:0]     amp_q;
   logic [TBITS-1:0]     scnt_q;
   logic [RAMP_BITS-1:0] rb_q;
   logic [15:0]          pcnt_q;

   logic [1:0]           eff_mode;
   logic [NBITS-1:0]     eff_const;
   logic [15:0]          eff_per;
   logic [15:0]          per_m1;
   logic [POSW-1:0]      eff_pos;
   logic [NBITS-1:0]     eff_amp;
   logic [TBITS-1:0]     beat_scnt;
   logic [RAMP_BITS-1:0] beat_rb;
   logic [15:0]          beat_pcnt;
   logic                 pulse_beat;
   logic [NCHAN*NSAMP*NBITS-1:0] dat_nxt;
   logic [NBITS-1:0]     smp_v;
   logic [RAMP_BITS-1:0] lo_v;

   // In IDLE the beat about to be written is beat 0, built straight from the inputs.
   always_comb begin
      eff_mode  = (state == ST_IDLE) ? mode_i         : mode_q;
      eff_const = (state == ST_IDLE) ? const_i        : const_q;
      eff_per   = (state == ST_IDLE) ? pulse_period_i : per_q;
      eff_pos   = (state == ST_IDLE) ? pulse_pos_i    : pos_q;
      eff_amp   = (state == ST_IDLE) ? pulse_amp_i    : amp_q;
      per_m1    = (eff_per == 16'd0) ? 16'd0 : eff_per - 16'd1;
      beat_scnt = (state == ST_IDLE) ? '0 : scnt_q;
      beat_rb   = (state == ST_IDLE) ? '0 : rb_q;
      beat_pcnt = (state == ST_IDLE) ? per_m1 : pcnt_q;
      pulse_beat = (eff_mode == M_PULSE) && (beat_pcnt == 16'd0);
   end

   always_comb begin
      dat_nxt = '0;
      smp_v   = '0;
      lo_v    = '0;
      for (int c = 0; c < NCHAN; c++) begin
         for (int s = 0; s < NSAMP; s++) begin
            lo_v = beat_rb + RAMP_BITS'(s);
            case (eff_mode)
               M_RAMP:  smp_v = (NBITS'(c % TAG_MOD) << RAMP_BITS) | NBITS'(lo_v);
               M_CONST: smp_v = eff_const;
               M_PULSE: smp_v = (pulse_beat && (POSW'(s) == eff_pos)) ? eff_amp : '0;
               default: smp_v = '0;
            endcase
            dat_nxt[NBITS*NSAMP*c + NBITS*s +: NBITS] = smp_v;
         end
      end
   end

   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         state             <= ST_IDLE;
         mode_q            <= '0;
         const_q           <= '0;
         per_q             <= '0;
         pos_q             <= '0;
         amp_q             <= '0;
         scnt_q            <= '0;
         rb_q              <= '0;
         pcnt_q            <= '0;
         ch_dat_o          <= '0;
         ch_valid_o        <= 1'b0;
         trig_time_o       <= '0;
         trig_time_valid_o <= 1'b0;
         trig_err_o        <= 1'b0;
      end else begin
         trig_time_valid_o <= 1'b0;
         trig_err_o        <= 1'b0;
         if (run_i) begin
            state <= ST_RUN;
            if (state == ST_IDLE) begin
               mode_q  <= mode_i;
               const_q <= const_i;
               per_q   <= pulse_period_i;
               pos_q   <= pulse_pos_i;
               amp_q   <= pulse_amp_i;
            end
            ch_dat_o   <= dat_nxt;
            ch_valid_o <= 1'b1;
            scnt_q     <= beat_scnt + TBITS'(NSAMP);
            rb_q       <= beat_rb + RAMP_BITS'(NSAMP);
            pcnt_q     <= (beat_pcnt == 16'd0) ? per_m1 : beat_pcnt - 16'd1;
         end else begin
            state      <= ST_IDLE;
            scnt_q     <= '0;
            rb_q       <= '0;
            pcnt_q     <= '0;
            ch_dat_o   <= '0;
            ch_valid_o <= 1'b0;
         end

         // Auto pulse owns the strobe; a coincident manual request is reported as dropped.
         if (run_i && pulse_beat) begin
            trig_time_valid_o <= 1'b1;
            trig_time_o       <= (beat_scnt + TBITS'(eff_pos)) & ~TBITS'(3);
            trig_err_o        <= trig_req_i;
         end else if (trig_req_i) begin
            if (trig_time_req_i[1:0] == 2'b00) begin
               trig_time_valid_o <= 1'b1;
               trig_time_o       <= trig_time_req_i;
            end else begin
               trig_err_o <= 1'b1;
            end
         end
      end
   end

endmodule
